// File: rtl/decode_if.sv
// decode_if: signal bundle between fetch/writeback and the decode stage.
//
// Fetch side drives instruction, pc4, stall and flush. Writeback drives
// wb_reg_write / wb_write_reg / wb_write_data. Decode returns the operands,
// the decoded fields and controls for execute, and branch_addr / do_branch
// for fetch.
//
// Flow control: there is no valid/ready pair on this boundary. stall holds
// the IF/ID register and flush loads a nop into it; flush wins over stall.
// Decode outputs are combinational from the IF/ID register and the register
// file, so fetch samples branch_addr / do_branch at the next rising edge.
//
// Modports:
//   master - fetch / writeback / testbench side (drives inputs to decode)
//   slave  - decode side
interface decode_if;
    logic [31:0] instruction;
    logic [31:0] pc4;
    logic        stall;
    logic        flush;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;

    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] sign_ext_imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] pc4_out;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;
    logic        branch;
    logic [1:0]  alu_op;
    logic [31:0] branch_addr;
    logic        do_branch;

    modport master (
        output instruction, pc4, stall, flush,
        output wb_reg_write, wb_write_reg, wb_write_data,
        input  rs_data, rt_data, sign_ext_imm, rt, rd, funct, pc4_out,
        input  reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst,
        input  branch, alu_op, branch_addr, do_branch
    );

    modport slave (
        input  instruction, pc4, stall, flush,
        input  wb_reg_write, wb_write_reg, wb_write_data,
        output rs_data, rt_data, sign_ext_imm, rt, rd, funct, pc4_out,
        output reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst,
        output branch, alu_op, branch_addr, do_branch
    );
endinterface

// File: rtl/decode.sv
// decode: instruction decode stage of the single-issue MIPS pipeline.
//
// Holds the IF/ID pipeline register and the 32x32 register file, generates
// the main control signals, and resolves beq in the same cycle (target and
// taken flag go straight back to fetch).
//
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high; register k resets to k, IF/ID to 0
//   bus    - decode_if.slave: fetch inputs (instruction, pc4, stall, flush),
//            writeback inputs (wb_reg_write, wb_write_reg, wb_write_data),
//            decode outputs (operands, fields, controls, branch_addr,
//            do_branch)
//
// Build option:
//   DECODE_BYPASS_EN - when defined, a writeback to the register being read
//                      in the same cycle is forwarded to rs_data / rt_data
//                      (and hence to the beq compare). When undefined the
//                      read shows the old value until the next cycle.
module decode (
    input  logic    clock,
    input  logic    reset,
    decode_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic        wb_en;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [5:0]  opcode;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm_ext;

    // Writes to $0 are dropped, so $0 keeps its reset value of 0.
    assign wb_en  = bus.wb_reg_write && (bus.wb_write_reg != 5'd0);
    assign rs_idx = if_instr_q[25:21];
    assign rt_idx = if_instr_q[20:16];
    assign opcode = if_instr_q[31:26];

    // IF/ID next state: flush beats stall.
    always_comb begin
        if_instr_d = if_instr_q;
        if_pc4_d   = if_pc4_q;
        if (bus.flush) begin
            if_instr_d = 32'd0;
            if_pc4_d   = 32'd0;
        end else if (!bus.stall) begin
            if_instr_d = bus.instruction;
            if_pc4_d   = bus.pc4;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_en) begin
            regs_d[bus.wb_write_reg] = bus.wb_write_data;
        end
    end

    // Reset takes priority over a coincident writeback.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) begin
                regs_q[k] <= 32'(k);
            end
            if_instr_q <= 32'd0;
            if_pc4_q   <= 32'd0;
        end else begin
            regs_q     <= regs_d;
            if_instr_q <= if_instr_d;
            if_pc4_q   <= if_pc4_d;
        end
    end

    // Asynchronous read ports.
`ifdef DECODE_BYPASS_EN
    always_comb begin
        rs_val = (rs_idx == 5'd0) ? 32'd0 : regs_q[rs_idx];
        rt_val = (rt_idx == 5'd0) ? 32'd0 : regs_q[rt_idx];
        if (wb_en && (bus.wb_write_reg == rs_idx)) begin
            rs_val = bus.wb_write_data;
        end
        if (wb_en && (bus.wb_write_reg == rt_idx)) begin
            rt_val = bus.wb_write_data;
        end
    end
`else
    always_comb begin
        rs_val = (rs_idx == 5'd0) ? 32'd0 : regs_q[rs_idx];
        rt_val = (rt_idx == 5'd0) ? 32'd0 : regs_q[rt_idx];
    end
`endif

    // Main control.
    always_comb begin
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.alu_src    = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.branch     = 1'b0;
        bus.alu_op     = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
                bus.alu_op    = 2'b10;
            end
            OP_LW: begin
                bus.alu_src    = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
                bus.mem_read   = 1'b1;
            end
            OP_SW: begin
                bus.alu_src   = 1'b1;
                bus.mem_write = 1'b1;
            end
            OP_BEQ: begin
                bus.branch = 1'b1;
                bus.alu_op = 2'b01;
            end
            default: begin
            end
        endcase
    end

    assign imm_ext = {{16{if_instr_q[15]}}, if_instr_q[15:0]};

    assign bus.rs_data      = rs_val;
    assign bus.rt_data      = rt_val;
    assign bus.sign_ext_imm = imm_ext;
    assign bus.rt           = rt_idx;
    assign bus.rd           = if_instr_q[15:11];
    assign bus.funct        = if_instr_q[5:0];
    assign bus.pc4_out      = if_pc4_q;

    // Target wraps modulo 2^32; the compare sees the (possibly bypassed)
    // operands. The delay-slot instruction behind a beq is not flushed here.
    assign bus.branch_addr  = if_pc4_q + {imm_ext[29:0], 2'b00};
    assign bus.do_branch    = bus.branch && (rs_val == rt_val);
endmodule
